serial_add_seq: RTL

SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

---
 rtl/serial_add_seq_pkg.sv | 19 +
 rtl/Mbledhesi.sv | 20 ++
 rtl/serial_add_seq.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/serial_add_seq_pkg.sv
// serial_add_seq_pkg -- shared types and constants for the bit-serial adder.
//   state_t       : controller states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand/result width
//   cnt_width()   : width of the bit counter for a given operand width
package serial_add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 24;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/Mbledhesi.sv
// Mbledhesi -- 1-bit full-adder cell.
//   a_i, b_i : operand bits
//   c_i      : carry in
//   s_o      : sum bit
//   c_o      : carry out
module Mbledhesi (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic p;

    assign p   = a_i ^ b_i;
    assign s_o = p ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & p);

endmodule

// File: rtl/serial_add_seq.sv
// serial_add_seq -- bit-serial adder/subtractor, one bit per clock, LSB first.
//   Clock, Reset      : clock, synchronous active-high reset
//   Start, Sub, A, B  : request, subtract select and operands (sampled in IDLE)
//   Result            : sum/difference, built up bit by bit, valid from Done
//   COUT, Overflow    : carry out of MSB, two's-complement overflow
//   Busy, Done        : high in RUN / one-cycle pulse in DONE
//   Zero              : result-is-zero flag, only with SERIAL_ADD_SEQ_ZERO_FLAG_EN
module serial_add_seq
    import serial_add_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Result,
    output logic             COUT,
    output logic             Overflow,
    output logic             Busy,
    output logic             Done
`ifdef SERIAL_ADD_SEQ_ZERO_FLAG_EN
    ,
    output logic             Zero
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             cell_s, cell_co;
    logic             last_bit;

    // Subtract is A + ~B + 1: B is inverted bit-wise here, the +1 comes
    // from the carry register being preloaded with Sub.
    Mbledhesi u_cell (
        .a_i (a_q[0]),
        .b_i (b_q[0] ^ sub_q),
        .c_i (carry_q),
        .s_o (cell_s),
        .c_o (cell_co)
    );

    assign last_bit = (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_ADD_SEQ_ZERO_FLAG_EN
    logic zero_q, zero_d;
    // Lower bits are already final when the MSB is being produced.
    always_comb begin
        zero_d = zero_q;
        if (state_q == RUN && last_bit) begin
            zero_d = ~cell_s & ~(|result_q[WIDTH-2:0]);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) zero_q <= 1'b0;
        else       zero_q <= zero_d;
    end

    assign Zero = zero_q;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    sub_d   = Sub;
                    carry_d = Sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d             = a_q >> 1;
                b_d             = b_q >> 1;
                carry_d         = cell_co;
                result_d[cnt_q] = cell_s;
                cnt_d           = cnt_q + CW'(1);
                if (last_bit) begin
                    cout_d  = cell_co;
                    // carry_q is the carry into the MSB on this cycle.
                    ovf_d   = carry_q ^ cell_co;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        case (state_q)
            RUN:     Busy = 1'b1;
            DONE:    Done = 1'b1;
            default: ;
        endcase
    end

    assign Result   = result_q;
    assign COUT     = cout_q;
    assign Overflow = ovf_q;

endmodule
